// File: rtl/motor_dir_sequencer.sv
// Direction sequencer for two DC-motor half-bridges: soft-start PWM ramps,
// enforced dead-time on stop/reversal, estop override and status LED.
module motor_dir_sequencer #(
  parameter int PWM_BITS         = 8,
  parameter int DUTY_MAX         = 255,
  parameter int RAMP_STEP_CYCLES = 256,
  parameter int DEADTIME_CYCLES  = 1000
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_motor1,
  input  logic                i_motor2,
  input  logic                i_estop,
  output logic                o_motor_on1,
  output logic                o_motor_on2,
  output logic [2:0]          o_led,
  output logic [PWM_BITS-1:0] o_duty,
  output logic                o_busy
);

  localparam int STEP_W = $clog2(RAMP_STEP_CYCLES + 1);
  localparam int DEAD_W = $clog2(DEADTIME_CYCLES + 1);
  localparam logic [PWM_BITS-1:0] DMAX      = PWM_BITS'(DUTY_MAX);
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(RAMP_STEP_CYCLES - 1);
  localparam logic [DEAD_W-1:0]   DEAD_LOAD = DEAD_W'(DEADTIME_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    RUN       = 3'd2,
    RAMP_DOWN = 3'd3,
    DEADTIME  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [1:0]          r_fSync, r_rSync, r_eSync;
  logic [PWM_BITS-1:0] r_duty, w_nextDuty;
  logic [PWM_BITS-1:0] r_cnt;
  logic [STEP_W-1:0]   r_stepCnt, w_nextStep;
  logic [DEAD_W-1:0]   r_deadCnt, w_nextDead;
  logic                r_dir, w_nextDir;
  logic                r_on1, r_on2;
  logic [2:0]          r_led, w_nextLed;
  logic                w_f, w_r, w_e;
  logic                w_fwd, w_rev, w_conflict, w_sameCmd;
  logic                w_stepHit, w_drive, w_pwm;

  assign w_f        = r_fSync[1];
  assign w_r        = r_rSync[1];
  assign w_e        = r_eSync[1];
  assign w_fwd      = w_f & ~w_r;
  assign w_rev      = w_r & ~w_f;
  assign w_conflict = w_f & w_r;
  assign w_sameCmd  = r_dir ? w_rev : w_fwd;
  assign w_stepHit  = (r_stepCnt == STEP_LAST);
  assign w_drive    = (r_state == RAMP_UP) || (r_state == RUN) || (r_state == RAMP_DOWN);
  assign w_pwm      = (r_cnt < r_duty);

  always_comb begin
    w_nextState = r_state;
    w_nextDuty  = r_duty;
    w_nextDir   = r_dir;
    w_nextDead  = r_deadCnt;
    case (r_state)
      IDLE: begin
        if (w_fwd) begin
          w_nextDir   = 1'b0;
          w_nextState = RAMP_UP;
        end else if (w_rev) begin
          w_nextDir   = 1'b1;
          w_nextState = RAMP_UP;
        end
      end
      RAMP_UP: begin
        if (!w_sameCmd) begin
          w_nextState = RAMP_DOWN;
        end else if (r_duty >= DMAX) begin
          w_nextState = RUN;
        end else if (w_stepHit) begin
          w_nextDuty = r_duty + PWM_BITS'(1);
          if (w_nextDuty == DMAX) w_nextState = RUN;
        end
      end
      RUN: begin
        w_nextDuty = DMAX;
        if (!w_sameCmd) w_nextState = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        // A returning same-direction command resumes the ramp without dead-time.
        if (w_sameCmd) begin
          w_nextState = RAMP_UP;
        end else if (r_duty == '0) begin
          w_nextState = DEADTIME;
          w_nextDead  = DEAD_LOAD;
        end else if (w_stepHit) begin
          w_nextDuty = r_duty - PWM_BITS'(1);
          if (w_nextDuty == '0) begin
            w_nextState = DEADTIME;
            w_nextDead  = DEAD_LOAD;
          end
        end
      end
      DEADTIME: begin
        if (w_e) w_nextDead = DEAD_LOAD;
        else if (r_deadCnt == '0) w_nextState = IDLE;
        else w_nextDead = r_deadCnt - DEAD_W'(1);
      end
      default: w_nextState = IDLE;
    endcase
    if (w_e && (r_state != DEADTIME)) begin
      w_nextState = DEADTIME;
      w_nextDuty  = '0;
      w_nextDead  = DEAD_LOAD;
    end
  end

  always_comb begin
    w_nextStep = '0;
    if ((w_nextState == r_state) && ((r_state == RAMP_UP) || (r_state == RAMP_DOWN)) && !w_stepHit)
      w_nextStep = r_stepCnt + STEP_W'(1);
  end

  always_comb begin
    w_nextLed = 3'b011;
    if (w_conflict) w_nextLed = 3'b000;
    else if (w_drive) w_nextLed = r_dir ? 3'b110 : 3'b101;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fSync   <= '0;
      r_rSync   <= '0;
      r_eSync   <= '0;
      r_state   <= IDLE;
      r_duty    <= '0;
      r_cnt     <= '0;
      r_stepCnt <= '0;
      r_deadCnt <= '0;
      r_dir     <= 1'b0;
      r_on1     <= 1'b0;
      r_on2     <= 1'b0;
      r_led     <= 3'b011;
    end else begin
      r_fSync   <= {r_fSync[0], i_motor1};
      r_rSync   <= {r_rSync[0], i_motor2};
      r_eSync   <= {r_eSync[0], i_estop};
      r_state   <= w_nextState;
      r_duty    <= w_nextDuty;
      r_cnt     <= r_cnt + PWM_BITS'(1);
      r_stepCnt <= w_nextStep;
      r_deadCnt <= w_nextDead;
      r_dir     <= w_nextDir;
      // Estop kills both bridges on the same edge it takes the FSM to DEADTIME.
      r_on1     <= w_pwm & ~r_dir & w_drive & ~w_e;
      r_on2     <= w_pwm & r_dir & w_drive & ~w_e;
      r_led     <= w_nextLed;
    end
  end

  assign o_motor_on1 = r_on1;
  assign o_motor_on2 = r_on2;
  assign o_led       = r_led;
  assign o_duty      = r_duty;
  assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_motor_dir_sequencer.sv
// Directed scoreboard bench for motor_dir_sequencer with a small configuration
// (4-bit PWM, 4-cycle ramp steps, 10-cycle dead-time).
module tb_motor_dir_sequencer;

  localparam int PWM_BITS = 4;
  localparam int DUTY_MAX = 15;
  localparam int STEP     = 4;
  localparam int DEAD     = 10;

  logic                clk    = 1'b0;
  logic                rst_n  = 1'b0;
  logic                motor1 = 1'b0;
  logic                motor2 = 1'b0;
  logic                estop  = 1'b0;
  logic                motorOn1, motorOn2, busy;
  logic [2:0]          led;
  logic [PWM_BITS-1:0] duty;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } expT;

  expT sb[$];
  int  testsRun = 0;
  int  testsFailed = 0;
  int  cycleNum = 0;
  int  lastOn1 = -1000000;
  int  lastOn2 = -1000000;
  int  minGap = 1000000;
  bit  sawOverlap = 1'b0;

  motor_dir_sequencer #(
    .PWM_BITS(PWM_BITS), .DUTY_MAX(DUTY_MAX),
    .RAMP_STEP_CYCLES(STEP), .DEADTIME_CYCLES(DEAD)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_motor1(motor1), .i_motor2(motor2),
    .i_estop(estop), .o_motor_on1(motorOn1), .o_motor_on2(motorOn2),
    .o_led(led), .o_duty(duty), .o_busy(busy)
  );

  always #5 clk = ~clk;

  // Tracks overlap and the shortest spacing between opposite-bridge highs.
  always @(negedge clk) begin
    cycleNum++;
    if (motorOn1 === 1'b1 && motorOn2 === 1'b1) sawOverlap = 1'b1;
    if (motorOn1 === 1'b1) begin
      if (cycleNum - lastOn2 < minGap) minGap = cycleNum - lastOn2;
      lastOn1 = cycleNum;
    end
    if (motorOn2 === 1'b1) begin
      if (cycleNum - lastOn1 < minGap) minGap = cycleNum - lastOn1;
      lastOn2 = cycleNum;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic pushExp(input string tag, input logic [31:0] exp);
    expT e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input logic [31:0] observed);
    expT e;
    testsRun++;
    if (sb.size() == 0) begin
      testsFailed++;
      $error("[TB] FAIL scoreboard_empty: observed %0d expected <entry>", observed);
    end else begin
      e = sb.pop_front();
      assert (observed === e.exp) else begin
        testsFailed++;
        $error("[TB] FAIL %s: observed %0d expected %0d", e.tag, observed, e.exp);
      end
    end
  endtask

  task automatic applyStimulus(input logic m1, input logic m2, input logic es);
    motor1 = m1;
    motor2 = m2;
    estop  = es;
  endtask

  task automatic waitDuty(input int val, input int limit, output int cycles, output int minDuty);
    cycles  = limit + 1;
    minDuty = 1 << PWM_BITS;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (int'(duty) < minDuty) minDuty = int'(duty);
      if (duty === PWM_BITS'(val)) begin
        cycles = c;
        break;
      end
    end
  endtask

  task automatic waitBusy(input logic val, input int limit, output int cycles);
    cycles = limit + 1;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (busy === val) begin
        cycles = c;
        break;
      end
    end
  endtask

  task automatic waitLed(input logic [2:0] val, input int limit, output int cycles);
    cycles = limit + 1;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (led === val) begin
        cycles = c;
        break;
      end
    end
  endtask

  task automatic countHigh(input int n, output int on1Cnt, output int on2Cnt);
    on1Cnt = 0;
    on2Cnt = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (motorOn1 === 1'b1) on1Cnt++;
      if (motorOn2 === 1'b1) on2Cnt++;
    end
  endtask

  initial begin
    int c, m, n1, n2;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    pushExp("rst_duty", 0);
    pushExp("rst_led", 3'b011);
    pushExp("rst_busy", 0);
    pushExp("rst_on1", 0);
    pushExp("rst_on2", 0);
    checkOutput(32'(duty));
    checkOutput(32'(led));
    checkOutput(32'(busy));
    checkOutput(32'(motorOn1));
    checkOutput(32'(motorOn2));
    rst_n = 1'b1;
    @(negedge clk);

    // Soft start forward: 2 sync edges, then 15 steps of 4 cycles.
    pushExp("soft_busy_latency", 3);
    pushExp("soft_led_latency", 1);
    pushExp("soft_ramp_cycles", 59);
    pushExp("soft_on1_per_period", 15);
    pushExp("soft_on2_per_period", 0);
    pushExp("soft_led_run", 3'b101);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitBusy(1'b1, 10, c);          checkOutput(c);
    waitLed(3'b101, 10, c);         checkOutput(c);
    waitDuty(15, 100, c, m);        checkOutput(c);
    countHigh(16, n1, n2);          checkOutput(n1); checkOutput(n2);
    checkOutput(32'(led));

    // Reversal: ramp down, dead-time, idle, then reverse ramp.
    pushExp("rev_down_cycles", 63);
    pushExp("rev_dead_to_idle", 10);
    pushExp("rev_idle_to_ramp", 1);
    pushExp("rev_led", 3'b110);
    pushExp("rev_up_cycles", 59);
    pushExp("rev_on1_per_period", 0);
    pushExp("rev_on2_per_period", 15);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitDuty(0, 100, c, m);         checkOutput(c);
    waitBusy(1'b0, 20, c);          checkOutput(c);
    waitBusy(1'b1, 10, c);          checkOutput(c);
    @(negedge clk);                 checkOutput(32'(led));
    waitDuty(15, 100, c, m);        checkOutput(c);
    countHigh(16, n1, n2);          checkOutput(n1); checkOutput(n2);

    // Conflict from RUN: led 000 after sync plus led register, ramp down, stay idle.
    pushExp("conf_led_latency", 3);
    pushExp("conf_down_cycles", 60);
    pushExp("conf_led_hold", 3'b000);
    pushExp("conf_dead_to_idle", 10);
    pushExp("conf_idle_busy", 0);
    pushExp("conf_idle_duty", 0);
    pushExp("conf_idle_led", 3'b000);
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitLed(3'b000, 10, c);         checkOutput(c);
    waitDuty(0, 100, c, m);         checkOutput(c);
    checkOutput(32'(led));
    waitBusy(1'b0, 20, c);          checkOutput(c);
    repeat (20) @(negedge clk);
    checkOutput(32'(busy));
    checkOutput(32'(duty));
    checkOutput(32'(led));

    // Estop mid ramp-up at duty 7.
    pushExp("estop_reach7", 31);
    pushExp("estop_latency", 3);
    pushExp("estop_on1", 0);
    pushExp("estop_on2", 0);
    pushExp("estop_hold_busy", 1);
    pushExp("estop_hold_duty", 0);
    pushExp("estop_release_to_idle", 12);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitDuty(7, 100, c, m);         checkOutput(c);
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitDuty(0, 10, c, m);          checkOutput(c);
    checkOutput(32'(motorOn1));
    checkOutput(32'(motorOn2));
    applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    checkOutput(32'(busy));
    checkOutput(32'(duty));
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitBusy(1'b0, 30, c);          checkOutput(c);

    // Re-grab during ramp-down at duty 9.
    pushExp("regrab_up", 63);
    pushExp("regrab_reach9", 27);
    pushExp("regrab_back_to_15", 27);
    pushExp("regrab_min_duty", 9);
    pushExp("no_overlap", 0);
    pushExp("deadtime_gap_ok", 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitDuty(15, 100, c, m);        checkOutput(c);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitDuty(9, 100, c, m);         checkOutput(c);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitDuty(15, 100, c, m);        checkOutput(c); checkOutput(m);
    checkOutput(32'(sawOverlap));
    checkOutput(32'(minGap > DEAD));

    // Asynchronous reset in RUN, applied between clock edges.
    pushExp("arst_on1", 0);
    pushExp("arst_on2", 0);
    pushExp("arst_led", 3'b011);
    pushExp("arst_duty", 0);
    pushExp("arst_busy", 0);
    pushExp("arst_idle_after_release", 0);
    pushExp("arst_restart_latency", 2);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput(32'(motorOn1));
    checkOutput(32'(motorOn2));
    checkOutput(32'(led));
    checkOutput(32'(duty));
    checkOutput(32'(busy));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput(32'(busy));
    waitBusy(1'b1, 10, c);          checkOutput(c);

    testsRun++;
    assert (sb.size() == 0) else begin
      testsFailed++;
      $error("[TB] FAIL scoreboard_drain: observed %0d entries expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
